// File: rtl/project2_seg7_decoder.sv
// Registered BCD/hex to seven-segment decoder for one digit.
// The code bits are synchronised through two flops before being decoded, and the result is registered.
module project2_seg7_decoder #(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g
);

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [3:0] code;
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [6:0] seg_d;
  logic [6:0] seg_q;

  assign code = {x3, x2, x1, x0};

  // Patterns are ordered {a,b,c,d,e,f,g} and use 1 for a lit segment.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    p = SEG_BLANK;
    case (v)
      4'd0:  p = 7'b1111110;
      4'd1:  p = 7'b0110000;
      4'd2:  p = 7'b1101101;
      4'd3:  p = 7'b1111001;
      4'd4:  p = 7'b0110011;
      4'd5:  p = 7'b1011011;
      4'd6:  p = 7'b1011111;
      4'd7:  p = 7'b1110000;
      4'd8:  p = 7'b1111111;
      4'd9:  p = 7'b1111011;
      4'd10: p = HEX_MODE ? 7'b1110111 : SEG_BLANK;
      4'd11: p = HEX_MODE ? 7'b0011111 : SEG_BLANK;
      4'd12: p = HEX_MODE ? 7'b1001110 : SEG_BLANK;
      4'd13: p = HEX_MODE ? 7'b0111101 : SEG_BLANK;
      4'd14: p = HEX_MODE ? 7'b1001111 : SEG_BLANK;
      4'd15: p = HEX_MODE ? 7'b1000111 : SEG_BLANK;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  assign seg_d = decode(sync2);

  // After reset is released, the first decode sees the zeroed synchroniser and displays "0".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 4'd0;
      sync2 <= 4'd0;
      seg_q <= SEG_BLANK;
    end else begin
      sync1 <= code;
      sync2 <= sync1;
      seg_q <= seg_d;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q ^ {7{ACTIVE_LOW}};

endmodule

// File: tb/tb_project2_seg7_decoder.sv
// Directed bench for the seven-segment decoder.
// It drives three instances (plain, hex glyphs, and inverted outputs) from the same inputs.
module tb_project2_seg7_decoder;

  logic clk;
  logic rst;
  logic x0, x1, x2, x3;
  logic [6:0] seg_n;
  logic [6:0] seg_h;
  logic [6:0] seg_l;

  int total;
  int bad;

  logic [6:0] dec_tab [0:15];
  logic [6:0] hex_tab [0:15];
  logic [6:0] exp_q [$];
  logic [3:0] seq [0:3];

  project2_seg7_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_plain (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .a(seg_n[6]), .b(seg_n[5]), .c(seg_n[4]), .d(seg_n[3]),
    .e(seg_n[2]), .f(seg_n[1]), .g(seg_n[0])
  );

  project2_seg7_decoder #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hex (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .a(seg_h[6]), .b(seg_h[5]), .c(seg_h[4]), .d(seg_h[3]),
    .e(seg_h[2]), .f(seg_h[1]), .g(seg_h[0])
  );

  project2_seg7_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_low (
    .clk(clk), .rst(rst), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .a(seg_l[6]), .b(seg_l[5]), .c(seg_l[4]), .d(seg_l[3]),
    .e(seg_l[2]), .f(seg_l[1]), .g(seg_l[0])
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks
  task automatic set_code(input logic [3:0] v);
    {x3, x2, x1, x0} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    dec_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
    hex_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    seq = '{4'd3, 4'd5, 4'd7, 4'd2};

    // Reset asserted before any clock edge, with code 8 on the inputs
    rst = 1'b0;
    set_code(4'd8);
    #1 rst = 1'b1;
    #1;
    check("rst_async_plain", seg_n, 7'b0000000);
    check("rst_async_hex", seg_h, 7'b0000000);
    check("rst_async_low", seg_l, 7'b1111111);
    tick();
    tick();
    check("rst_held_plain", seg_n, 7'b0000000);
    rst = 1'b0;

    // The zeroed synchroniser shows "0" until code 8 arrives on the third edge
    tick();
    check("rel_e1", seg_n, 7'b1111110);
    tick();
    check("rel_e2", seg_n, 7'b1111110);
    tick();
    check("rel_e3_plain", seg_n, 7'b1111111);
    check("rel_e3_low", seg_l, 7'b0000000);

    // Sweep every code, holding each one for four edges
    for (int i = 0; i < 16; i++) begin
      set_code(4'(i));
      repeat (4) tick();
      check($sformatf("sweep_plain_%0d", i), seg_n, dec_tab[i]);
      check($sformatf("sweep_hex_%0d", i), seg_h, hex_tab[i]);
      check($sformatf("sweep_low_%0d", i), seg_l, ~dec_tab[i]);
    end

    // Latency check when the code steps from 1 to 4
    set_code(4'd1);
    repeat (4) tick();
    check("lat_base", seg_n, 7'b0110000);
    set_code(4'd4);
    tick();
    check("lat_e1", seg_n, 7'b0110000);
    tick();
    check("lat_e2", seg_n, 7'b0110000);
    tick();
    check("lat_e3", seg_n, 7'b0110011);

    // New code every cycle; each one should come out in order, three edges later
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        set_code(seq[k]);
        exp_q.push_back(dec_tab[seq[k]]);
      end
      tick();
      if (k >= 2) check($sformatf("stream_%0d", k - 2), seg_n, exp_q.pop_front());
    end

    // Short reset pulse in the middle of a clock cycle while "9" is displayed
    set_code(4'd9);
    repeat (4) tick();
    check("mid_pre", seg_n, 7'b1111011);
    rst = 1'b1;
    #1;
    check("mid_rst_plain", seg_n, 7'b0000000);
    check("mid_rst_low", seg_l, 7'b1111111);
    #1 rst = 1'b0;
    tick();
    check("mid_e1", seg_n, 7'b1111110);
    tick();
    check("mid_e2", seg_n, 7'b1111110);
    tick();
    check("mid_e3", seg_n, 7'b1111011);
    check("mid_e3_hex", seg_h, 7'b1111011);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
